// File: rtl/fpu_seq.sv
// fpu_seq: command sequencer for the floating-point unit.
// Buffers commands, reads operands, waits the unit latency, writes back.
module fpu_seq #(
   parameter int WIDTH      = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int LAT_ADD    = 3,
   parameter int LAT_MUL    = 3,
   parameter int LAT_DIV    = 8,
   parameter int LAT_SQR    = 8,
   parameter int LAT_CMP    = 2
) (
   input  logic              clk,
   input  logic              rstp,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [2:0]        cmd_rm,
   output logic              rf_rd_en,
   output logic [ADDR_W-1:0] rf_rd_addr1,
   output logic [ADDR_W-1:0] rf_rd_addr2,
   input  logic [WIDTH-1:0]  rf_rd_data1,
   input  logic [WIDTH-1:0]  rf_rd_data2,
   output logic [2:0]        op_sel,
   output logic [2:0]        op_rm,
   output logic [WIDTH-1:0]  op_in1,
   output logic [WIDTH-1:0]  op_in2,
   input  logic [WIDTH-1:0]  res_data,
   input  logic [4:0]        res_flags,
   input  logic [2:0]        cmp_flags,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [WIDTH-1:0]  rf_wr_data,
   output logic              rsp_valid,
   output logic              cmp_less,
   output logic              cmp_eq,
   output logic              cmp_great,
   output logic [4:0]        fflags,
   input  logic              fflags_clr,
   output logic              busy
);

   localparam int CW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = CW + 1;

   typedef struct packed {
      logic [2:0]        op;
      logic [2:0]        rm;
      logic [ADDR_W-1:0] src1;
      logic [ADDR_W-1:0] src2;
      logic [ADDR_W-1:0] dst;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   cmd_t              fifo_mem [FIFO_DEPTH];
   cmd_t              head;
   logic [CW-1:0]     wr_ptr;
   logic [CW-1:0]     rd_ptr;
   logic [CNTW-1:0]   count;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   state_t            state;
   state_t            state_nxt;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] dst;
   logic [WIDTH-1:0]  res;
   logic [4:0]        flags_q;
   logic [2:0]        cmp_q;
   logic [4:0]        wb_flags;
   logic              is_wr;

   function automatic logic [7:0] lat_of(input logic [2:0] op);
      case (op)
         3'd0:    lat_of = 8'(LAT_ADD - 1);
         3'd1:    lat_of = 8'(LAT_MUL - 1);
         3'd2:    lat_of = 8'(LAT_DIV - 1);
         3'd3:    lat_of = 8'(LAT_SQR - 1);
         3'd4:    lat_of = 8'(LAT_CMP - 1);
         default: lat_of = 8'd0;
      endcase
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CNTW'(FIFO_DEPTH));
   assign cmd_ready = !rstp && !full;
   assign push      = cmd_valid && cmd_ready;
   assign head      = fifo_mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{op: cmd_op, rm: cmd_rm, src1: cmd_src1,
                               src2: cmd_src2, dst: cmd_dst};
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = READ;
            end
         end
         READ: state_nxt = EXEC;
         EXEC: begin
            if (cnt == 8'd0) state_nxt = WB;
         end
         WB: begin
            pop       = !empty;
            state_nxt = empty ? IDLE : READ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rf_rd_en    = pop;
   assign rf_rd_addr1 = pop ? head.src1 : '0;
   assign rf_rd_addr2 = pop ? head.src2 : '0;

   assign is_wr      = (op_sel < 3'd4);
   assign rsp_valid  = (state == WB);
   assign rf_we      = rsp_valid && is_wr;
   assign rf_wr_addr = rf_we ? dst : '0;
   assign rf_wr_data = rf_we ? res : '0;
   // illegal opcodes raise only the invalid flag
   assign wb_flags   = (op_sel > 3'd4) ? 5'b10000 : flags_q;

   always_ff @(posedge clk) begin
      if (rstp) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cnt       <= '0;
         op_sel    <= '0;
         op_rm     <= '0;
         dst       <= '0;
         op_in1    <= '0;
         op_in2    <= '0;
         res       <= '0;
         flags_q   <= '0;
         cmp_q     <= '0;
         cmp_less  <= 1'b0;
         cmp_eq    <= 1'b0;
         cmp_great <= 1'b0;
         fflags    <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + CW'(1);
         if (pop) rd_ptr <= rd_ptr + CW'(1);
         count <= count + CNTW'(push) - CNTW'(pop);
         if (pop) begin
            op_sel <= head.op;
            op_rm  <= head.rm;
            dst    <= head.dst;
         end
         if (state == READ) begin
            op_in1 <= rf_rd_data1;
            op_in2 <= rf_rd_data2;
            cnt    <= lat_of(op_sel);
         end
         if (state == EXEC) begin
            if (cnt == 8'd0) begin
               res     <= res_data;
               flags_q <= res_flags;
               cmp_q   <= cmp_flags;
            end else begin
               cnt <= cnt - 8'd1;
            end
         end
         if (rsp_valid && op_sel == 3'd4) begin
            {cmp_less, cmp_eq, cmp_great} <= cmp_q;
         end
         fflags <= (fflags_clr ? 5'b0 : fflags) |
                   (rsp_valid ? wb_flags : 5'b0);
      end
   end

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: directed stimulus with a per-cycle timing/value model
// of the sequencer, SRAM and arithmetic-unit stubs.
module tb_fpu_seq;

   localparam int W  = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rstp = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [AW-1:0] cmd_src1 = '0;
   logic [AW-1:0] cmd_src2 = '0;
   logic [AW-1:0] cmd_dst = '0;
   logic [2:0]    cmd_rm = '0;
   logic          rf_rd_en;
   logic [AW-1:0] rf_rd_addr1;
   logic [AW-1:0] rf_rd_addr2;
   logic [W-1:0]  rf_rd_data1 = '0;
   logic [W-1:0]  rf_rd_data2 = '0;
   logic [2:0]    op_sel;
   logic [2:0]    op_rm;
   logic [W-1:0]  op_in1;
   logic [W-1:0]  op_in2;
   logic [W-1:0]  res_data;
   logic [4:0]    res_flags;
   logic [2:0]    cmp_flags;
   logic          rf_we;
   logic [AW-1:0] rf_wr_addr;
   logic [W-1:0]  rf_wr_data;
   logic          rsp_valid;
   logic          cmp_less;
   logic          cmp_eq;
   logic          cmp_great;
   logic [4:0]    fflags;
   logic          fflags_clr = 1'b0;
   logic          busy;

   always #5 clk = ~clk;

   fpu_seq dut (
      .clk(clk), .rstp(rstp),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
      .cmd_dst(cmd_dst), .cmd_rm(cmd_rm),
      .rf_rd_en(rf_rd_en), .rf_rd_addr1(rf_rd_addr1),
      .rf_rd_addr2(rf_rd_addr2), .rf_rd_data1(rf_rd_data1),
      .rf_rd_data2(rf_rd_data2),
      .op_sel(op_sel), .op_rm(op_rm), .op_in1(op_in1), .op_in2(op_in2),
      .res_data(res_data), .res_flags(res_flags), .cmp_flags(cmp_flags),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rsp_valid(rsp_valid), .cmp_less(cmp_less), .cmp_eq(cmp_eq),
      .cmp_great(cmp_great), .fflags(fflags), .fflags_clr(fflags_clr),
      .busy(busy)
   );

   // register-file contents restored on every reset
   function automatic logic [W-1:0] init_val(input int i);
      case (i)
         1:       init_val = 32'h3F80_0000;
         2:       init_val = 32'h4000_0000;
         default: init_val = 32'h1111_0000 + 32'(i * 7);
      endcase
   endfunction

   logic [W-1:0] rf [32];
   always @(posedge clk) begin
      if (rstp) begin
         for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      end else begin
         if (rf_rd_en) begin
            rf_rd_data1 <= rf[rf_rd_addr1];
            rf_rd_data2 <= rf[rf_rd_addr2];
         end
         if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
      end
   end

   // unit stub: result mixes the operands, flags indexed by opcode
   logic [W-1:0] stub_res = 32'h3FC0_0000;
   logic [2:0]   stub_cmp = 3'b000;
   logic [4:0]   ftbl [8];
   assign res_data  = stub_res ^ op_in1 ^ op_in2;
   assign res_flags = ftbl[op_sel];
   assign cmp_flags = stub_cmp;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int op);
      case (op)
         0: lat_of = 3;
         1: lat_of = 3;
         2: lat_of = 8;
         3: lat_of = 8;
         4: lat_of = 2;
         default: lat_of = 1;
      endcase
   endfunction

   typedef struct {
      int op; int rm; int s1; int s2; int d; int p; int w;
   } mcmd_t;

   // model: p = edge that pops the command, w = edge that enters write-back
   mcmd_t        q[$];
   int           cur = 0;
   int           last_w = 0;
   bit           seen_rst = 0;
   logic [4:0]   mf = '0;
   logic [2:0]   mc = '0;
   logic [W-1:0] mrf [32];

   int n_we = 0;
   int last_we_cyc = 0;
   int last_rd_cyc = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic [W-1:0]  last_wr_data = '0;
   int acc_q[$];
   int rsp_q[$];

   always @(negedge clk) begin : model
      bit wb;
      bit we_exp;
      int nf;
      int rdi;
      mcmd_t c;
      wb  = 0;
      nf  = 0;
      rdi = -1;
      we_exp = 0;
      if (seen_rst) begin
         wb = (q.size() > 0) && (q[0].w == cur);
         we_exp = wb && (q[0].op < 4);
         foreach (q[i]) begin
            if (q[i].p > cur) nf++;
            if (q[i].p == cur + 1) rdi = i;
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(wb));
         chk("rf_we", 32'(rf_we), 32'(we_exp));
         if (we_exp) begin
            chk("wr_addr", 32'(rf_wr_addr), 32'(q[0].d));
            chk("wr_data", rf_wr_data,
                stub_res ^ mrf[q[0].s1] ^ mrf[q[0].s2]);
         end
         chk("rd_en", 32'(rf_rd_en), 32'(rdi >= 0));
         if (rdi >= 0) begin
            chk("rd_addr1", 32'(rf_rd_addr1), 32'(q[rdi].s1));
            chk("rd_addr2", 32'(rf_rd_addr2), 32'(q[rdi].s2));
         end
         if (q.size() > 0 && cur >= q[0].p && cur <= q[0].w) begin
            chk("op_sel", 32'(op_sel), 32'(q[0].op));
            chk("op_rm", 32'(op_rm), 32'(q[0].rm));
         end
         if (q.size() > 0 && cur > q[0].p && cur <= q[0].w) begin
            chk("op_in1", op_in1, mrf[q[0].s1]);
            chk("op_in2", op_in2, mrf[q[0].s2]);
         end
         chk("cmd_ready", 32'(cmd_ready), 32'(!rstp && nf < 4));
         chk("busy", 32'(busy), 32'(q.size() > 0));
         chk("fflags", 32'(fflags), 32'(mf));
         chk("cmp", 32'({cmp_less, cmp_eq, cmp_great}), 32'(mc));
      end
      if (rf_we === 1'b1) begin
         n_we++;
         last_we_cyc  = cur;
         last_wr_addr = rf_wr_addr;
         last_wr_data = rf_wr_data;
      end
      if (rf_rd_en === 1'b1) last_rd_cyc = cur;
      if (rsp_valid === 1'b1) rsp_q.push_back(cur);
      if (rstp) begin
         q.delete();
         mf = '0;
         mc = '0;
         last_w = 0;
         for (int i = 0; i < 32; i++) mrf[i] = init_val(i);
         seen_rst = 1;
      end else if (seen_rst) begin
         if (fflags_clr) mf = '0;
         if (wb) begin
            mf |= (q[0].op > 4) ? 5'b10000 : ftbl[q[0].op];
            if (q[0].op == 4) mc = stub_cmp;
            if (q[0].op < 4)
               mrf[q[0].d] = stub_res ^ mrf[q[0].s1] ^ mrf[q[0].s2];
            void'(q.pop_front());
         end
         if (cmd_valid && nf < 4) begin
            c.op = int'(cmd_op);
            c.rm = int'(cmd_rm);
            c.s1 = int'(cmd_src1);
            c.s2 = int'(cmd_src2);
            c.d  = int'(cmd_dst);
            c.p  = (cur + 2 > last_w + 1) ? cur + 2 : last_w + 1;
            c.w  = c.p + 1 + lat_of(c.op);
            last_w = c.w;
            q.push_back(c);
            acc_q.push_back(cur + 1);
         end
      end
      cur++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int op, input int s1, input int s2,
                       input int d, input int rm);
      bit ok;
      ok        = 0;
      cmd_op    = 3'(op);
      cmd_src1  = AW'(s1);
      cmd_src2  = AW'(s2);
      cmd_dst   = AW'(d);
      cmd_rm    = 3'(rm);
      cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         step();
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int we0;
      ftbl[0] = 5'b00000; ftbl[1] = 5'b00001; ftbl[2] = 5'b01000;
      ftbl[3] = 5'b00001; ftbl[4] = 5'b00000; ftbl[5] = 5'b00110;
      ftbl[6] = 5'b00110; ftbl[7] = 5'b00110;

      // reset held with a command offered
      rstp = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = 3'd0; cmd_src1 = 5'd1; cmd_src2 = 5'd2; cmd_dst = 5'd9;
      step();
      chk("ready_in_reset", 32'(cmd_ready), 32'd0);
      step();
      chk("ready_in_reset2", 32'(cmd_ready), 32'd0);
      rstp = 1'b0;
      cmd_valid = 1'b0;
      step();
      chk("ready_after_reset", 32'(cmd_ready), 32'd1);
      chk("fflags_after_reset", 32'(fflags), 32'd0);
      chk("busy_after_reset", 32'(busy), 32'd0);
      chk("rf_we_after_reset", 32'(rf_we), 32'd0);

      // single add: 1.0 + 2.0 -> 3.0 into r3
      stub_res = 32'h3FC0_0000;
      send(0, 1, 2, 3, 0);
      a0 = acc_q[$];
      wait_idle(50);
      chk("add_latency", 32'(last_we_cyc - a0), 32'd5);
      chk("add_wr_addr", 32'(last_wr_addr), 32'd3);
      chk("add_wr_data", last_wr_data, 32'h4040_0000);
      chk("add_fflags", 32'(fflags), 32'd0);

      // mixed back-to-back ops with distinct rounding modes
      stub_res = 32'h0F0F_0F0F;
      send(0, 5, 6, 25, 1);
      send(1, 7, 8, 26, 2);
      send(3, 9, 4, 27, 4);
      wait_idle(100);

      // backpressure: one in flight plus a full FIFO
      acc_q.delete();
      rsp_q.delete();
      for (int i = 0; i < 5; i++) send(2, 1, 2, 10 + i, 3);
      cmd_op = 3'd2; cmd_src1 = 5'd1; cmd_src2 = 5'd2; cmd_dst = 5'd15;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("ready_low_full", 32'(cmd_ready), 32'd0);
      send(2, 1, 2, 15, 3);
      wait_idle(200);
      chk("bp_accept5", 32'(acc_q[4] - acc_q[0]), 32'd4);
      chk("bp_accept6", 32'(acc_q[5] - acc_q[0]), 32'd12);
      chk("bp_retires", 32'(rsp_q.size()), 32'd6);
      for (int i = 1; i < 6 && i < rsp_q.size(); i++)
         chk("bp_spacing", 32'(rsp_q[i] - rsp_q[i-1]), 32'd10);

      // sticky flags with a clear coinciding with write-back
      fflags_clr = 1'b1;
      step();
      fflags_clr = 1'b0;
      chk("fflags_cleared", 32'(fflags), 32'd0);
      send(2, 1, 2, 21, 0);
      send(1, 1, 2, 22, 0);
      wait_rsp(50);
      step();
      chk("fflags_div", 32'(fflags), 32'b01000);
      repeat (4) step();
      chk("mul_wb_now", 32'(rsp_valid), 32'd1);
      fflags_clr = 1'b1;
      step();
      fflags_clr = 1'b0;
      chk("fflags_clr_wb", 32'(fflags), 32'b00001);
      wait_idle(50);

      // compare, then an illegal opcode
      stub_cmp = 3'b100;
      we0 = n_we;
      send(4, 3, 4, 5, 0);
      wait_idle(50);
      chk("cmp_less", 32'(cmp_less), 32'd1);
      chk("cmp_eq", 32'(cmp_eq), 32'd0);
      chk("cmp_no_we", 32'(n_we), 32'(we0));
      rsp_q.delete();
      send(6, 1, 2, 7, 0);
      wait_idle(50);
      chk("illegal_retire", 32'(rsp_q[$] - last_rd_cyc), 32'd3);
      chk("illegal_no_we", 32'(n_we), 32'(we0));
      chk("illegal_fflags", 32'(fflags), 32'b10001);

      // reset during a sqrt with two commands queued
      send(3, 1, 2, 20, 0);
      send(0, 1, 2, 23, 0);
      send(1, 3, 4, 24, 0);
      repeat (3) step();
      chk("sqrt_in_exec", 32'(op_sel), 32'd3);
      rstp = 1'b1;
      we0 = n_we;
      step();
      rstp = 1'b0;
      repeat (40) step();
      chk("midrst_no_we", 32'(n_we), 32'(we0));
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_fflags", 32'(fflags), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
